// File: rtl/rom_port_arbiter_if.sv
`default_nettype none
// ==========================================================================
// rom_port_arbiter_if : fetch/data requester ports and genrom read port bundle
// Rev 1.0
// ==========================================================================
interface rom_port_arbiter_if #(
  parameter int AW    = 4,
  parameter int EXTRA = 4
);
  localparam int DW = (2 ** EXTRA) * 8;

  logic             f_req;
  logic [AW:0]      f_addr;
  logic [EXTRA-1:0] f_extra;
  logic [AW:0]      f_lower;
  logic [AW:0]      f_upper;
  logic             f_ack;
  logic [DW-1:0]    f_data;
  logic             f_error;

  logic             d_req;
  logic [AW:0]      d_addr;
  logic [EXTRA-1:0] d_extra;
  logic [AW:0]      d_lower;
  logic [AW:0]      d_upper;
  logic             d_ack;
  logic [DW-1:0]    d_data;
  logic             d_error;

  logic [AW:0]      mem_addr;
  logic [EXTRA-1:0] mem_extra;
  logic [AW:0]      mem_lower_bound;
  logic [AW:0]      mem_upper_bound;
  logic [DW-1:0]    mem_data;
  logic             mem_error;
  logic             busy;

  // Arbiter side
  modport slave (
    input  f_req, f_addr, f_extra, f_lower, f_upper,
           d_req, d_addr, d_extra, d_lower, d_upper,
           mem_data, mem_error,
    output f_ack, f_data, f_error, d_ack, d_data, d_error,
           mem_addr, mem_extra, mem_lower_bound, mem_upper_bound, busy
  );

  // Requesters plus ROM side
  modport master (
    output f_req, f_addr, f_extra, f_lower, f_upper,
           d_req, d_addr, d_extra, d_lower, d_upper,
           mem_data, mem_error,
    input  f_ack, f_data, f_error, d_ack, d_data, d_error,
           mem_addr, mem_extra, mem_lower_bound, mem_upper_bound, busy
  );
endinterface
`default_nettype wire

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ==========================================================================
// rom_port_arbiter : round-robin fetch/data arbiter and sequencer for genrom
// Rev 1.0
// ==========================================================================
module rom_port_arbiter #(
  parameter int AW          = 4,
  parameter int EXTRA       = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  rom_port_arbiter_if.slave bus
);
  localparam int DW = (2 ** EXTRA) * 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             sel_q, sel_d;    // 1 = data port owns the access
  logic             last_q, last_d;  // 1 = data port granted last
  logic [AW:0]      addr_q, addr_d;
  logic [EXTRA-1:0] extra_q, extra_d;
  logic [AW:0]      lower_q, lower_d;
  logic [AW:0]      upper_q, upper_d;
  logic             f_ack_q, f_ack_d, d_ack_q, d_ack_d;
  logic             f_err_q, f_err_d, d_err_q, d_err_d;
  logic [DW-1:0]    f_data_q, f_data_d, d_data_q, d_data_d;
  logic             win_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      extra_q  <= '0;
      lower_q  <= '0;
      upper_q  <= '1;
      f_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      f_err_q  <= 1'b0;
      d_err_q  <= 1'b0;
      f_data_q <= '0;
      d_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      extra_q  <= extra_d;
      lower_q  <= lower_d;
      upper_q  <= upper_d;
      f_ack_q  <= f_ack_d;
      d_ack_q  <= d_ack_d;
      f_err_q  <= f_err_d;
      d_err_q  <= d_err_d;
      f_data_q <= f_data_d;
      d_data_q <= d_data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    last_d   = last_q;
    addr_d   = addr_q;
    extra_d  = extra_q;
    lower_d  = lower_q;
    upper_d  = upper_q;
    f_ack_d  = 1'b0;
    d_ack_d  = 1'b0;
    f_err_d  = f_err_q;
    d_err_d  = d_err_q;
    f_data_d = f_data_q;
    d_data_d = d_data_q;
    // On a tie the port that did not win last time gets the grant
    win_data = bus.d_req && (!bus.f_req || !last_q);

    case (state_q)
      S_IDLE: begin
        if (bus.f_req || bus.d_req) begin
          sel_d   = win_data;
          last_d  = win_data;
          addr_d  = win_data ? bus.d_addr  : bus.f_addr;
          extra_d = win_data ? bus.d_extra : bus.f_extra;
          lower_d = win_data ? bus.d_lower : bus.f_lower;
          upper_d = win_data ? bus.d_upper : bus.f_upper;
          cnt_d   = 4'(ROM_LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (sel_q) begin
            d_data_d = bus.mem_data;
            d_err_d  = bus.mem_error;
            d_ack_d  = 1'b1;
          end else begin
            f_data_d = bus.mem_data;
            f_err_d  = bus.mem_error;
            f_ack_d  = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.f_ack           = f_ack_q;
  assign bus.f_data          = f_data_q;
  assign bus.f_error         = f_err_q;
  assign bus.d_ack           = d_ack_q;
  assign bus.d_data          = d_data_q;
  assign bus.d_error         = d_err_q;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_extra       = extra_q;
  assign bus.mem_lower_bound = lower_q;
  assign bus.mem_upper_bound = upper_q;
  assign bus.busy            = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_rom_port_arbiter : vector table, corner sequences and random traffic
// Rev 1.0
// ==========================================================================
module tb_rom_port_arbiter;
  localparam int AW    = 4;
  localparam int EXTRA = 4;
  localparam int LAT   = 1;
  localparam int DW    = (2 ** EXTRA) * 8;
  localparam int NB    = 2 ** EXTRA;
  localparam int RS    = 2 ** (AW + 1);

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rom_port_arbiter_if #(.AW(AW), .EXTRA(EXTRA)) bus ();

  rom_port_arbiter #(.AW(AW), .EXTRA(EXTRA), .ROM_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- ROM stand-in: byte array behind a LAT-deep pipeline
  logic [7:0]    rom       [RS];
  logic [DW-1:0] pipe_data [LAT];
  logic          pipe_err  [LAT];

  function automatic logic [DW-1:0] rom_read(input logic [AW:0] a, input logic [EXTRA-1:0] x);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      if (i <= int'(x)) r[8*i +: 8] = rom[(int'(a) + i) % RS];
    return r;
  endfunction

  function automatic logic rom_err(input logic [AW:0] a, input logic [EXTRA-1:0] x,
                                   input logic [AW:0] lo, input logic [AW:0] hi);
    return (int'(a) < int'(lo)) || (int'(a) + int'(x) > int'(hi));
  endfunction

  always @(posedge clk) begin
    pipe_data[0] <= rom_read(bus.mem_addr, bus.mem_extra);
    pipe_err[0]  <= rom_err(bus.mem_addr, bus.mem_extra, bus.mem_lower_bound, bus.mem_upper_bound);
    for (int i = 1; i < LAT; i++) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_err[i]  <= pipe_err[i-1];
    end
  end
  assign bus.mem_data  = pipe_data[LAT-1];
  assign bus.mem_error = pipe_err[LAT-1];

  // ---------------- Transaction-level reference model (edge counting)
  int               e;
  int               m_g;
  logic             m_act, m_sel, m_last;
  logic [AW:0]      m_addr, m_lo, m_hi;
  logic [EXTRA-1:0] m_x;
  logic             xf_ack, xd_ack, xf_err, xd_err, x_busy;
  logic [DW-1:0]    xf_data, xd_data;
  logic [AW:0]      xm_addr, xm_lo, xm_hi;
  logic [EXTRA-1:0] xm_x;

  task automatic model_reset();
    e = 0; m_g = 0; m_act = 1'b0; m_sel = 1'b0; m_last = 1'b1;
    m_addr = '0; m_lo = '0; m_hi = '1; m_x = '0;
    xf_ack = 1'b0; xd_ack = 1'b0; xf_err = 1'b0; xd_err = 1'b0; x_busy = 1'b0;
    xf_data = '0; xd_data = '0;
    xm_addr = '0; xm_x = '0; xm_lo = '0; xm_hi = '1;
  endtask

  task automatic model_step();
    e++;
    xf_ack = 1'b0;
    xd_ack = 1'b0;
    if (m_act) begin
      if (e == m_g + LAT + 1) begin
        if (m_sel) begin
          xd_ack = 1'b1; xd_data = rom_read(m_addr, m_x); xd_err = rom_err(m_addr, m_x, m_lo, m_hi);
        end else begin
          xf_ack = 1'b1; xf_data = rom_read(m_addr, m_x); xf_err = rom_err(m_addr, m_x, m_lo, m_hi);
        end
      end
      if (e == m_g + LAT + 2) m_act = 1'b0;
    end else if (bus.f_req || bus.d_req) begin
      m_sel  = (bus.f_req && bus.d_req) ? !m_last : bus.d_req;
      m_last = m_sel;
      m_g    = e;
      m_act  = 1'b1;
      m_addr = m_sel ? bus.d_addr  : bus.f_addr;
      m_x    = m_sel ? bus.d_extra : bus.f_extra;
      m_lo   = m_sel ? bus.d_lower : bus.f_lower;
      m_hi   = m_sel ? bus.d_upper : bus.f_upper;
      xm_addr = m_addr; xm_x = m_x; xm_lo = m_lo; xm_hi = m_hi;
    end
    x_busy = m_act;
  endtask

  // ---------------- Checking helpers
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("m_ctrl", {bus.f_ack, bus.d_ack, bus.f_error, bus.d_error, bus.busy},
                  {xf_ack, xd_ack, xf_err, xd_err, x_busy});
    chk("m_mem", {bus.mem_addr, bus.mem_extra, bus.mem_lower_bound, bus.mem_upper_bound},
                 {xm_addr, xm_x, xm_lo, xm_hi});
    chk("m_fdata", bus.f_data, xf_data);
    chk("m_ddata", bus.d_data, xd_data);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    #1;
  endtask

  task automatic set_idle();
    bus.f_req = 1'b0; bus.f_addr = '0; bus.f_extra = '0; bus.f_lower = '0; bus.f_upper = '1;
    bus.d_req = 1'b0; bus.d_addr = '0; bus.d_extra = '0; bus.d_lower = '0; bus.d_upper = '1;
  endtask

  task automatic drive(input logic port, input logic [AW:0] a, input logic [EXTRA-1:0] x,
                       input logic [AW:0] lo, input logic [AW:0] hi);
    if (port) begin
      bus.d_addr = a; bus.d_extra = x; bus.d_lower = lo; bus.d_upper = hi; bus.d_req = 1'b1;
    end else begin
      bus.f_addr = a; bus.f_extra = x; bus.f_lower = lo; bus.f_upper = hi; bus.f_req = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  typedef struct {
    logic             port;
    logic [AW:0]      addr;
    logic [EXTRA-1:0] x;
    logic [AW:0]      lo;
    logic [AW:0]      hi;
    logic [DW-1:0]    data;
    logic             err;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t          tbl [6];
    int            lat, nack, noth, fa, da;
    logic          own, oth, got_e;
    logic [DW-1:0] got_d, exp_fd, exp_dd;
    logic [7:0]    seq;

    tbl[0] = '{1'b0, 5'd1, 4'd7, 5'd0,  5'd31, 128'hC000000000000000,   1'b0};
    tbl[1] = '{1'b1, 5'd0, 4'd0, 5'd0,  5'd31, 128'h44,                 1'b0};
    tbl[2] = '{1'b1, 5'd2, 4'd3, 5'd0,  5'd3,  128'h0,                  1'b1};
    tbl[3] = '{1'b0, 5'd0, 4'd8, 5'd0,  5'd31, 128'hC00000000000000044, 1'b0};
    tbl[4] = '{1'b0, 5'd9, 4'd0, 5'd10, 5'd31, 128'h5A,                 1'b1};
    tbl[5] = '{1'b1, 5'd8, 4'd1, 5'd0,  5'd9,  128'h5AC0,               1'b0};

    for (int i = 0; i < RS; i++) rom[i] = 8'h00;
    rom[0] = 8'h44;
    rom[8] = 8'hC0;
    rom[9] = 8'h5A;

    // Reset holds every output at its reset value even with a request pending
    reset = 1'b0;
    model_reset();
    set_idle();
    drive(1'b0, 5'd3, 4'd2, 5'd1, 5'd9);
    repeat (3) tick();
    chk("rst_ctrl", {bus.f_ack, bus.d_ack, bus.f_error, bus.d_error, bus.busy}, '0);
    chk("rst_fdata", bus.f_data, '0);
    chk("rst_ddata", bus.d_data, '0);
    chk("rst_mem", {bus.mem_addr, bus.mem_extra, bus.mem_lower_bound, bus.mem_upper_bound},
                   {5'd0, 4'd0, 5'd0, 5'h1F});

    // Tie straight after reset: fetch first, data four cycles later
    set_idle();
    reset = 1'b1;
    drive(1'b0, 5'd1, 4'd7, 5'd0, 5'h1F);
    drive(1'b1, 5'd0, 4'd0, 5'd0, 5'h1F);
    fa = -1; da = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.f_ack) begin if (fa < 0) fa = c; bus.f_req = 1'b0; end
      if (bus.d_ack) begin if (da < 0) da = c; bus.d_req = 1'b0; end
    end
    chk("tie_f_edge", fa, LAT + 2);
    chk("tie_d_edge", da, LAT + 6);
    chk("tie_f_data", bus.f_data, 128'hC000000000000000);
    chk("tie_d_data8", bus.d_data[7:0], 8'h44);

    // Continuous contention alternates F, D, F, D
    pulse_reset();
    drive(1'b0, 5'd1, 4'd7, 5'd0, 5'h1F);
    drive(1'b1, 5'd0, 4'd0, 5'd0, 5'h1F);
    nack = 0; seq = '0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus.f_ack) begin nack++; seq = {seq[6:0], 1'b0}; end
      if (bus.d_ack) begin nack++; seq = {seq[6:0], 1'b1}; end
    end
    chk("cont_count", nack, 4);
    chk("cont_order", seq, 8'b0101);
    set_idle();
    repeat (4) tick();

    // Single-port vectors, including bound errors on both sides
    pulse_reset();
    exp_fd = '0; exp_dd = '0;
    for (int k = 0; k < 6; k++) begin
      set_idle();
      drive(tbl[k].port, tbl[k].addr, tbl[k].x, tbl[k].lo, tbl[k].hi);
      lat = -1; nack = 0; noth = 0; got_d = '0; got_e = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        tick();
        own = tbl[k].port ? bus.d_ack : bus.f_ack;
        oth = tbl[k].port ? bus.f_ack : bus.d_ack;
        if (own) begin
          nack++;
          if (lat < 0) lat = c;
          got_d = tbl[k].port ? bus.d_data  : bus.f_data;
          got_e = tbl[k].port ? bus.d_error : bus.f_error;
          bus.f_req = 1'b0;
          bus.d_req = 1'b0;
        end
        if (oth) noth++;
      end
      chk($sformatf("v%0d_latency", k), lat, LAT + 2);
      chk($sformatf("v%0d_ack_count", k), nack, 1);
      chk($sformatf("v%0d_other_ack", k), noth, 0);
      chk($sformatf("v%0d_data", k), got_d, tbl[k].data);
      chk($sformatf("v%0d_error", k), got_e, tbl[k].err);
      chk($sformatf("v%0d_other_data", k), tbl[k].port ? bus.f_data : bus.d_data,
          tbl[k].port ? exp_fd : exp_dd);
      chk($sformatf("v%0d_busy_end", k), bus.busy, 1'b0);
      if (tbl[k].port) exp_dd = tbl[k].data;
      else             exp_fd = tbl[k].data;
    end

    // Reset during WAIT aborts the access without an ack
    set_idle();
    drive(1'b0, 5'd1, 4'd7, 5'd0, 5'h1F);
    tick();
    tick();
    chk("mid_busy_wait", bus.busy, 1'b1);
    reset = 1'b0;
    model_reset();
    #2;
    chk("mid_rst_ctrl", {bus.f_ack, bus.d_ack, bus.busy}, '0);
    chk("mid_rst_mem", {bus.mem_addr, bus.mem_upper_bound}, {5'd0, 5'h1F});
    bus.f_req = 1'b0;
    tick();
    reset = 1'b1;
    nack = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (bus.f_ack || bus.d_ack) nack++;
    end
    chk("mid_no_ack", nack, 0);
    bus.f_req = 1'b1;
    lat = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      tick();
      if (bus.f_ack) begin lat = c; bus.f_req = 1'b0; end
    end
    chk("mid_new_latency", lat, LAT + 2);
    chk("mid_new_data", bus.f_data, 128'hC000000000000000);
    tick();
    chk("mid_new_idle", bus.busy, 1'b0);

    // Random traffic against the reference model
    set_idle();
    pulse_reset();
    for (int i = 0; i < RS; i++) rom[i] = 8'($urandom);
    for (int n = 0; n < 800; n++) begin
      reset = 1'b1;
      bus.f_req   = ($urandom_range(0, 9) < 6);
      bus.d_req   = ($urandom_range(0, 9) < 6);
      bus.f_addr  = 5'($urandom);
      bus.f_extra = 4'($urandom);
      bus.f_lower = 5'($urandom_range(0, 8));
      bus.f_upper = 5'($urandom_range(8, 31));
      bus.d_addr  = 5'($urandom);
      bus.d_extra = 4'($urandom);
      bus.d_lower = 5'($urandom_range(0, 8));
      bus.d_upper = 5'($urandom_range(8, 31));
      if (n > 10 && $urandom_range(0, 149) == 0) begin
        reset = 1'b0;
        model_reset();
      end
      tick();
      check_model();
    end
    reset = 1'b1;
    set_idle();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Two-requester arbiter and sequencer for the single `genrom` read port. It shares the port between the CPU instruction-fetch path and the data (load) path. It registers the granted request's address, extra-byte count and bounds onto the ROM, waits out the ROM read latency, then captures `mem_data`/`mem_error` and returns them to the winner with a one-cycle acknowledge. It sits between `cpu` and `genrom` and replaces the direct CPU-to-ROM connection.

## Interface
- `AW`, 4: ROM address width parameter; address buses are `AW+1` bits, matching `genrom` `AW`.
- `EXTRA`, 4: extra-byte field width; data width is DW = 2**EXTRA*8 (128 by default).
- `ROM_LATENCY`, 1: clock edges from the ROM sampling its address until `mem_data` is valid; legal range 1..15.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `f_req` in 1: fetch request; level, held until `f_ack`.
- `f_addr` in AW+1: fetch byte address.
- `f_extra` in EXTRA: fetch extra-byte count.
- `f_lower`, `f_upper` in AW+1 each: fetch bounds.
- `f_ack` out 1: one-cycle completion pulse.
- `f_data` out DW: fetch read data.
- `f_error` out 1: fetch bound error.
- `d_req`, `d_addr`, `d_extra`, `d_lower`, `d_upper`, `d_ack`, `d_data`, `d_error`: same as the `f_` ports, for the data port.
- `mem_addr` out AW+1: to ROM `addr`, registered.
- `mem_extra` out EXTRA: to ROM `extra`, registered.
- `mem_lower_bound`, `mem_upper_bound` out AW+1: to ROM bounds, registered.
- `mem_data` in DW: from ROM.
- `mem_error` in 1: from ROM.
- `busy` out 1: high in every state other than IDLE.

## Operation
- States:
  - IDLE: samples requests.
  - WAIT: counter `cnt` runs down from ROM_LATENCY.
  - RESP: ack cycle.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request: grant it.
- IDLE, both requests: grant the port not granted last (round-robin). `last` resets to "data", so fetch wins the first tie.
- On a grant:
  - Register the winner's addr, extra, lower and upper onto the `mem_*` outputs.
  - Set `sel` to the winner and update `last`.
  - Load `cnt` = ROM_LATENCY and go to WAIT.
- WAIT:
  - Decrement `cnt` every edge.
  - On the edge where `cnt` == 0, capture `mem_data` into the selected port's `*_data` and `mem_error` into `*_error`, set that port's `*_ack` = 1, and go to RESP.
- RESP: clear the ack and go to IDLE. Captured data/error hold until the same port's next completion.
- `mem_*` outputs hold their last granted values while idle.
- The non-selected port's data, error and ack are never disturbed.
- `req` dropped mid-access is a protocol violation. The access still completes and the ack still pulses.
- `req` held high after ack counts as a new request in IDLE and is arbitrated normally.
- A bound error is reported alongside whatever data the ROM returns. The arbiter does not suppress or retry.

## Timing
- Reset (async, `reset`=0) forces the following, regardless of state; a reset during WAIT/RESP aborts the access with no ack:
  - state IDLE, `cnt` 0, `last` = data;
  - all acks, data and errors 0;
  - `mem_addr` 0, `mem_extra` 0, `mem_lower_bound` 0, `mem_upper_bound` all-ones;
  - `busy` 0.
- Grant edge G, with the request sampled at G:
  - ROM samples the address at G+1;
  - data is captured at edge G+ROM_LATENCY+1;
  - ack is high for the single cycle after that edge;
  - IDLE is re-entered at G+ROM_LATENCY+2.
- The earliest next grant is at edge G+ROM_LATENCY+3. Occupancy is ROM_LATENCY+3 cycles per access (4 at default).
- A requester sampling ack at edge G+ROM_LATENCY+2 can drop `req` in time for no re-grant.
- Requests arriving during WAIT/RESP wait. There is no queueing beyond the held level.
- Both ports continuously requesting: grants alternate F, D, F, D. No port waits more than one access.

## Test plan
- Reset check: hold `reset`=0 → every output equals its reset value; `busy`=0.
- Single fetch: ROM bytes 44 00 00 00 00 00 00 00 C0 at addr 0..8; `f_addr`=1, `f_extra`=7, bounds 0/all-ones.
  - Required: `f_ack` high only in the cycle after G+2, and `f_data[63:0]`=64'hC000000000000000.
  - Required: `f_error`=0, and `d_ack` never asserts.
- Tie after reset: `f_req` and `d_req` rise together with `d_addr`=0, `d_extra`=0.
  - Required: fetch granted at G, data granted at G+4.
  - Required: `d_data[7:0]`=8'h44, and the fetch result is unchanged.
- Continuous contention: both requests held high for 16 cycles → 4 acks, alternating F, D, F, D.
- Bound error: `d_addr`=2, `d_extra`=3, `d_upper`=3 → `d_ack` pulses with `d_error`=1; a following in-bounds fetch returns `f_error`=0.
- Reset mid-access: pull `reset` low during WAIT, then release → no ack, `busy`=0; a new `f_req` completes normally in 4 cycles.
